// File: rtl/collatz_sched_pkg.sv
// Shared types and default widths for the Collatz scheduler, datapath and datapath FSM.
// Latency: none (declarations only).
// Backpressure: not applicable.
package collatz_pkg;

    localparam int SEED_W_DEF = 16;
    localparam int STEP_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/collatz_sched_if.sv
// Requester, datapath and response signals of the Collatz scheduler.
// Latency: none (wiring only).
// Backpressure: rsp_valid/rsp_ready; requesters hold req/seed until they see gnt.
interface collatz_sched_if
    import collatz_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int SEED_W = SEED_W_DEF,
    parameter int STEP_W = STEP_W_DEF
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*SEED_W-1:0] seed;
    logic [N_REQ-1:0]        gnt;
    logic                    dp_start;
    logic [SEED_W-1:0]       dp_seed;
    logic                    dp_done;
    logic [STEP_W-1:0]       dp_steps;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [STEP_W-1:0]       rsp_steps;
    logic                    rsp_err;
    logic                    busy;

    // Scheduler side.
    modport slave (
        input  req, seed, dp_done, dp_steps, rsp_ready,
        output gnt, dp_start, dp_seed, rsp_valid, rsp_id, rsp_steps, rsp_err, busy
    );

    // Requester / datapath / consumer side.
    modport master (
        output req, seed, dp_done, dp_steps, rsp_ready,
        input  gnt, dp_start, dp_seed, rsp_valid, rsp_id, rsp_steps, rsp_err, busy
    );

endinterface

// File: rtl/collatz_sched_rr_arbiter.sv
// Round-robin winner: first set request scanning upward from last+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller samples the result only when it can accept a job.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int pos;

    // Walk from the farthest offset down to last+1 so the nearest requester overwrites the rest.
    always_comb begin
        gnt_oh = '0;
        idx    = '0;
        any    = |req;
        pos    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos = (int'(last) + k) % N_REQ;
            if (req[pos]) begin
                gnt_oh      = '0;
                gnt_oh[pos] = 1'b1;
                idx         = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/collatz_sched.sv
// Shares one Collatz step-count datapath among N_REQ requesters with round-robin arbitration and a watchdog.
// Latency: grant 1 cycle after the IDLE decision; response 1 cycle after dp_done (or timeout).
// Backpressure: response held stable until rsp_ready; no arbitration happens while not IDLE.
module collatz_sched
    import collatz_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int SEED_W  = SEED_W_DEF,
    parameter int STEP_W  = STEP_W_DEF,
    parameter int TIMEOUT = 1048575
) (
    input logic            clk,
    input logic            rst,
    collatz_sched_if.slave bus
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    sched_state_t      state;
    logic [ID_W-1:0]   last;
    logic [TW-1:0]     tcnt;

    logic [N_REQ-1:0]  gnt_q;
    logic              start_q;
    logic [SEED_W-1:0] seed_q;
    logic              valid_q;
    logic [ID_W-1:0]   id_q;
    logic [STEP_W-1:0] steps_q;
    logic              err_q;
    logic              busy_q;

    logic [N_REQ-1:0]  arb_oh;
    logic [ID_W-1:0]   arb_idx;
    logic              arb_any;
    logic [SEED_W-1:0] arb_seed;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (bus.req),
        .last   (last),
        .gnt_oh (arb_oh),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign arb_seed = bus.seed[int'(arb_idx)*SEED_W +: SEED_W];

    // Scheduler FSM: arbitration, launch pulse, watchdog and response hold, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last    <= ID_W'(N_REQ - 1);
            tcnt    <= '0;
            gnt_q   <= '0;
            start_q <= 1'b0;
            seed_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            steps_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            gnt_q   <= '0;
            start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        last   <= arb_idx;
                        id_q   <= arb_idx;
                        gnt_q  <= arb_oh;
                        busy_q <= 1'b1;
                        if (arb_seed != '0) begin
                            seed_q  <= arb_seed;
                            start_q <= 1'b1;
                            state   <= LAUNCH;
                        end else begin
                            // A zero seed never reaches the datapath; answer with an error at once.
                            steps_q <= '0;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end
                LAUNCH: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.dp_done) begin
                        // Completion takes precedence over a timeout in the same cycle.
                        steps_q <= bus.dp_steps;
                        err_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end else if (tcnt == T_LAST) begin
                        steps_q <= '0;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.dp_start  = start_q;
    assign bus.dp_seed   = seed_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_steps = steps_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/collatz_sched.md
# collatz_sched

Round-robin scheduler that shares the single Collatz step-count datapath (the FSM-controlled even/odd engine) among `N_REQ` requesters. It arbitrates pending requests, launches the datapath with the granted seed, and supervises completion with a watchdog timeout. It returns the step count, or an error, to the originating requester over a valid/ready response channel. It sits between the requester-side bus and the datapath's `st` / seed / done interface.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `SEED_W`, 16: seed width.
- `STEP_W`, 20: step-count width.
- `TIMEOUT`, 1048575: maximum WAIT cycles before abort (≥ 2).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in N_REQ: level request per requester.
- `seed` in N_REQ*SEED_W: seeds, requester i at bits [i*SEED_W +: SEED_W].
- `gnt` out N_REQ: one-hot, one-cycle grant pulse.
- `dp_start` out 1: one-cycle start pulse to the datapath (drives `st`).
- `dp_seed` out SEED_W: seed to the datapath; held stable from LAUNCH until leaving WAIT.
- `dp_done` in 1: datapath finished (returned to Hold).
- `dp_steps` in STEP_W: datapath step count, valid with `dp_done`.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out clog2(N_REQ): requester index of the response.
- `rsp_steps` out STEP_W: step count (0 on error).
- `rsp_err` out 1: 1 means seed was 0 or a timeout occurred.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States:
  - IDLE: waits for any `req`. Winner i = first set bit scanning upward from `last+1` (mod N_REQ). On a winner, captures `seed[i]`, captures `id = i`, and sets `last = i`.
    - If the captured seed is nonzero, goes to LAUNCH.
    - If the captured seed is 0, goes to RESP with err=1, steps=0, and the datapath is never started.
  - LAUNCH: `dp_start=1` for exactly one cycle, then WAIT.
  - WAIT: counts cycles in `tcnt`, which is cleared on entry.
    - `dp_done` sampled high: `rsp_steps ← dp_steps`, err=0, go to RESP.
    - `tcnt == TIMEOUT-1` without done: err=1, steps=0, go to RESP.
    - `dp_done` and timeout in the same cycle: done wins.
  - RESP: `rsp_valid=1` with id/steps/err held stable. Returns to IDLE on the cycle `rsp_ready` is sampled high.
- `gnt[i]` pulses during the cycle after the IDLE decision (the first LAUNCH cycle, or the first RESP cycle for seed 0).
- Requesters must drop `req` or change `seed` only after observing `gnt`.
- `dp_done` outside WAIT is ignored.
- `req` changes while not IDLE have no effect; arbitration occurs only in IDLE.
- Fairness: a continuously requesting requester waits at most N_REQ-1 jobs.
- Widths: `tcnt` is clog2(TIMEOUT+1) bits, saturating, with no wrap. `dp_steps` passes through unmodified.
- Reset (asynchronous, any state, including mid-WAIT):
  - State goes to IDLE.
  - `last = N_REQ-1`, so requester 0 has first priority.
  - `tcnt=0`.
  - All outputs go to 0: `gnt`, `dp_start`, `dp_seed`, `rsp_valid`, `rsp_id`, `rsp_steps`, `rsp_err`, `busy`.
  - The datapath shares `rst`, so no job is left pending.

## Timing
- All outputs are registered.
- Request sampled at edge t (IDLE):
  - `gnt` and `dp_start` are high during cycle t+1.
  - The earliest `dp_done` is sampled at edge t+2 (WAIT).
  - `rsp_valid` is high from cycle t+D+2, where D is the number of WAIT cycles up to and including the `dp_done` sample.
- Seed 0: `gnt` and `rsp_valid` are both high at cycle t+1.
- Timeout: `rsp_valid` is high TIMEOUT cycles after WAIT entry plus 1.
- A handshake at edge u puts the block in IDLE at u+1. The next arbitration is sampled at edge u+1, giving a minimum of 1 idle cycle between jobs.
- `rsp_valid` never drops without `rsp_ready`, and its payload never changes while valid.

## Structure
- `collatz_pkg` holds:
  - The state enum (IDLE, LAUNCH, WAIT, RESP).
  - The default SEED_W/STEP_W constants, shared with the datapath and its FSM.
- Sub-module `rr_arbiter`:
  - Combinational round-robin winner from `req` and `last`.
  - Outputs one-hot grant, index, and any-request.
- Top level holds the FSM, capture registers, and timeout counter.

## Test plan
- Single job: reset, then `req=0001`, seed[0]=6. Expect `gnt=0001` and `dp_start` pulse with `dp_seed=6`. The datapath model returns 8 steps, so `rsp_valid` carries id=0, steps=8, err=0.
- Round robin: `req=1111` held with seeds 3, 7, 1, 27 and `rsp_ready=1`. Expect grant order 0,1,2,3,0. Responses carry id 0→3 with steps 7, 16, 0, 111.
- Zero seed: seed[2]=0 with `req=0100`. Expect `gnt=0100` and `rsp_valid` at t+1 with err=1, steps=0, and `dp_start` never asserted.
- Timeout: TIMEOUT=16 and the datapath never sets `dp_done`. Expect `rsp_err=1`, steps=0, `rsp_valid` 17 cycles after WAIT entry. A subsequent job then completes normally.
- Backpressure plus simultaneity: hold `rsp_ready=0` for 10 cycles. Expect the payload stable and no new `gnt` while `req` is pending. Then drive `dp_done` on the exact timeout cycle and expect err=0.
- Reset mid-WAIT: assert `rst` asynchronously during WAIT. Expect all outputs 0 immediately and state IDLE. After release, requester 0 wins when all request.
